uart_tx_sequencer: RTL

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// Round-robin character sequencer: brings up a 16550-style UART over APB, then
// grants requesters one at a time, polls LSR.THRE and writes each character to THR.
module uart_tx_sequencer #(
    parameter int          N_REQ     = 4,
    parameter logic [15:0] DIVISOR   = 16'h001B,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               init_done_o,
    output logic               err_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [31:0]        paddr_o,
    output logic [31:0]        pwdata_o,
    input  logic [31:0]        prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_IER = 3'd1;
    localparam logic [2:0] REG_FCR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;
    localparam logic [2:0] LAST_INIT_STEP = 3'd5;

    typedef enum logic [1:0] {INIT, IDLE, POLL, WRITE} state_t;

    state_t             r_state;
    logic [2:0]         r_step;
    logic [PTR_W-1:0]   r_ptr;
    logic [7:0]         r_byte;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [31:0]        r_paddr;
    logic [31:0]        r_pwdata;
    logic               r_init_done;
    logic               r_err;

    logic               w_any;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [7:0]         w_byte;
    logic [N_REQ-1:0]   w_grant;
    logic               w_done;
    logic               w_unused_prdata;

    function automatic logic [31:0] reg_addr(input logic [2:0] k);
        return BASE_ADDR + {27'd0, k, 2'b00};
    endfunction

    // Bring-up order: DLAB on, divisor low/high, 8N1 with DLAB off, FIFOs on, IRQs off.
    function automatic logic [2:0] init_reg(input logic [2:0] step);
        case (step)
            3'd0:    return REG_LCR;
            3'd1:    return REG_THR;
            3'd2:    return REG_IER;
            3'd3:    return REG_LCR;
            3'd4:    return REG_FCR;
            default: return REG_IER;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [2:0] step);
        case (step)
            3'd0:    return 8'h80;
            3'd1:    return DIVISOR[7:0];
            3'd2:    return DIVISOR[15:8];
            3'd3:    return 8'h03;
            3'd4:    return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        int sum;
        int nxt;
        logic vld;
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_byte      = '0;
        w_grant     = '0;
        sum         = 0;
        nxt         = 0;
        vld         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(r_ptr) + k;
            if (sum >= N_REQ) sum = sum - N_REQ;
            vld = 1'b0;
            for (int j = 0; j < N_REQ; j++) begin
                if (j == sum) vld = req_valid_i[j];
            end
            if (!w_any && vld) begin
                w_any       = 1'b1;
                w_grant_idx = PTR_W'(sum);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (w_grant_idx == PTR_W'(j)) w_byte = req_data_i[8*j +: 8];
        end
        nxt = int'(w_grant_idx) + 1;
        if (nxt >= N_REQ) nxt = 0;
        w_ptr_nxt = PTR_W'(nxt);
        if (r_state == IDLE && w_any) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (w_grant_idx == PTR_W'(j)) w_grant[j] = 1'b1;
            end
        end
    end

    assign w_done          = r_psel & r_penable & pready_i;
    assign w_unused_prdata = ^{prdata_i[31:6], prdata_i[4:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= INIT;
            r_step      <= '0;
            r_ptr       <= '0;
            r_byte      <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_done && pslverr_i) r_err <= 1'b1;
            case (r_state)
                INIT: begin
                    if (!r_psel) begin
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b1;
                        r_paddr  <= reg_addr(init_reg(r_step));
                        r_pwdata <= {24'h0, init_data(r_step)};
                    end else if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready_i) begin
                        if (r_step == LAST_INIT_STEP) begin
                            r_psel      <= 1'b0;
                            r_penable   <= 1'b0;
                            r_pwrite    <= 1'b0;
                            r_init_done <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_step    <= r_step + 3'd1;
                            r_penable <= 1'b0;
                            r_paddr   <= reg_addr(init_reg(r_step + 3'd1));
                            r_pwdata  <= {24'h0, init_data(r_step + 3'd1)};
                        end
                    end
                end
                IDLE: begin
                    if (w_any) begin
                        r_byte    <= w_byte;
                        r_ptr     <= w_ptr_nxt;
                        r_state   <= POLL;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= reg_addr(REG_LSR);
                        r_pwdata  <= '0;
                    end
                end
                POLL: begin
                    if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready_i) begin
                        r_penable <= 1'b0;
                        // An errored LSR read is treated as "not empty" and retried.
                        if (prdata_i[5] && !pslverr_i) begin
                            r_state  <= WRITE;
                            r_pwrite <= 1'b1;
                            r_paddr  <= reg_addr(REG_THR);
                            r_pwdata <= {24'h0, r_byte};
                        end
                    end
                end
                WRITE: begin
                    if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready_i) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign req_ready_o = w_grant;
    assign init_done_o = r_init_done;
    assign err_o       = r_err;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;

endmodule
